// File: rtl/ysyx_25030081_rf_mp_pkg.sv
// Shared constants for the multi-port register file and its read ports.
package ysyx_25030081_rf_mp_pkg;

    // Default geometry of the integer register file.
    localparam int RF_ADDR_WIDTH_DEF = 5;
    localparam int DATA_WIDTH_DEF    = 32;

    // Architectural register that reads as zero, is never written and is never busy.
    localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/ysyx_25030081_rf_rdport.sv
// One read port: zero-register check, write->read bypass select and busy masking.
module ysyx_25030081_rf_rdport
    import ysyx_25030081_rf_mp_pkg::*;
#(
    parameter int RF_ADDR_WIDTH = RF_ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int NR_WR         = 1,
    parameter int BYPASS        = 1
) (
    input  logic                          rst,
    input  logic [RF_ADDR_WIDTH-1:0]      raddr,
    input  logic [NR_WR-1:0]              wen,
    input  logic [NR_WR*RF_ADDR_WIDTH-1:0] waddr,
    input  logic [NR_WR*DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH-1:0]         rf_val,
    input  logic                          busy_val,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic                          rbusy
);

    localparam logic [RF_ADDR_WIDTH-1:0] ZERO_ADDR = RF_ADDR_WIDTH'(REG_ZERO);

    logic                  hit;
    logic [DATA_WIDTH-1:0] fwd;

    // Find the highest-index enabled writer to this address, then mask for reg 0 and reset.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
        hit = 1'b0;
        fwd = rf_val;
        // Ascending scan: a later (higher-index) match overrides an earlier one.
        for (int k = 0; k < NR_WR; k++) begin
            if (wen[k] && (waddr[k*RF_ADDR_WIDTH +: RF_ADDR_WIDTH] == raddr)) begin
                hit = 1'b1;
                fwd = wdata[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        if (rst || (raddr == ZERO_ADDR)) begin
            rdata = '0;
        end else if (BYPASS != 0) begin
            rdata = fwd;
        end else begin
            rdata = rf_val;
        end
        // A writer this cycle retires the producer the reader was waiting on.
        rbusy = !rst && busy_val && !((BYPASS != 0) && hit);
    end

endmodule

// File: rtl/ysyx_25030081_rf_mp.sv
// Multi-port integer register file with write->read bypass and a per-register scoreboard.
module ysyx_25030081_rf_mp
    import ysyx_25030081_rf_mp_pkg::*;
#(
    parameter int RF_ADDR_WIDTH = RF_ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int NR_RD         = 2,
    parameter int NR_WR         = 1,
    parameter int BYPASS        = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NR_WR-1:0]               wen,
    input  logic [NR_WR*RF_ADDR_WIDTH-1:0] waddr,
    input  logic [NR_WR*DATA_WIDTH-1:0]    wdata,
    input  logic [NR_RD*RF_ADDR_WIDTH-1:0] raddr,
    output logic [NR_RD*DATA_WIDTH-1:0]    rdata,
    output logic [NR_RD-1:0]               rbusy,
    input  logic                           iss_en,
    input  logic [RF_ADDR_WIDTH-1:0]       iss_addr,
    output logic [2**RF_ADDR_WIDTH-1:0]    busy
);

    localparam int DEPTH = 2**RF_ADDR_WIDTH;
    localparam logic [RF_ADDR_WIDTH-1:0] ZERO_ADDR = RF_ADDR_WIDTH'(REG_ZERO);

    logic [DATA_WIDTH-1:0] rf [DEPTH];
    logic [DEPTH-1:0]      busy_q;
    logic [DEPTH-1:0]      set_vec;
    logic [DEPTH-1:0]      clr_vec;

    // Storage: writes to reg 0 are dropped; the highest-index port wins on an address clash.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the whole array is reset because reset must read back zero everywhere, so it maps to flops, not RAM.
            for (int r = 0; r < DEPTH; r++) begin
                rf[r] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignment; the last scheduled update to the same entry (highest k) takes effect.
            for (int k = 0; k < NR_WR; k++) begin
                if (wen[k] && (waddr[k*RF_ADDR_WIDTH +: RF_ADDR_WIDTH] != ZERO_ADDR)) begin
                    rf[waddr[k*RF_ADDR_WIDTH +: RF_ADDR_WIDTH]] <= wdata[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Decode the issue (set) and write-back (clear) requests into one-hot vectors; reg 0 is excluded.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (iss_en) begin
            set_vec[iss_addr] = 1'b1;
        end
        for (int k = 0; k < NR_WR; k++) begin
            if (wen[k]) begin
                clr_vec[waddr[k*RF_ADDR_WIDTH +: RF_ADDR_WIDTH]] = 1'b1;
            end
        end
        set_vec[0] = 1'b0;
        clr_vec[0] = 1'b0;
    end

    // Scoreboard: a new producer (set) supersedes a retiring one (clear) in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= (busy_q & ~clr_vec) | set_vec;
        end
    end

    assign busy = busy_q;

    for (genvar i = 0; i < NR_RD; i++) begin : g_rd
        logic [RF_ADDR_WIDTH-1:0] ra;
        assign ra = raddr[i*RF_ADDR_WIDTH +: RF_ADDR_WIDTH];

        ysyx_25030081_rf_rdport #(
            .RF_ADDR_WIDTH (RF_ADDR_WIDTH),
            .DATA_WIDTH    (DATA_WIDTH),
            .NR_WR         (NR_WR),
            .BYPASS        (BYPASS)
        ) u_rdport (
            .rst      (rst),
            .raddr    (ra),
            .wen      (wen),
            .waddr    (waddr),
            .wdata    (wdata),
            .rf_val   (rf[ra]),
            .busy_val (busy_q[ra]),
            .rdata    (rdata[i*DATA_WIDTH +: DATA_WIDTH]),
            .rbusy    (rbusy[i])
        );
    end

endmodule

// File: tb/tb_ysyx_25030081_rf_mp.sv
// Bench: two register files (bypass on/off) driven in lockstep and compared to an array model.
module tb_ysyx_25030081_rf_mp;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int NR_RD = 2;
    localparam int NR_WR = 2;
    localparam int DEPTH = 32;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NR_WR-1:0]      wen;
    logic [NR_WR*AW-1:0]   waddr;
    logic [NR_WR*DW-1:0]   wdata;
    logic [NR_RD*AW-1:0]   raddr;
    logic                  iss_en;
    logic [AW-1:0]         iss_addr;

    logic [NR_RD*DW-1:0]   rdata_b, rdata_n;
    logic [NR_RD-1:0]      rbusy_b, rbusy_n;
    logic [DEPTH-1:0]      busy_b, busy_n;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: architectural contents and pending-writer flags.
    logic [DW-1:0] mdl_rf   [DEPTH];
    bit            mdl_busy [DEPTH];

    always #5 clk = ~clk;

    ysyx_25030081_rf_mp #(
        .RF_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NR_RD(NR_RD), .NR_WR(NR_WR), .BYPASS(1)
    ) dut_b (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
        .iss_en(iss_en), .iss_addr(iss_addr), .busy(busy_b)
    );

    ysyx_25030081_rf_mp #(
        .RF_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NR_RD(NR_RD), .NR_WR(NR_WR), .BYPASS(0)
    ) dut_n (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata_n), .rbusy(rbusy_n),
        .iss_en(iss_en), .iss_addr(iss_addr), .busy(busy_n)
    );

    function automatic logic [DW-1:0] exp_rdata(int i, bit byp);
        int a = int'(raddr[i*AW +: AW]);
        logic [DW-1:0] v;
        if (rst || a == 0) return '0;
        v = mdl_rf[a];
        if (byp) begin
            for (int k = 0; k < NR_WR; k++) begin
                if (wen[k] && int'(waddr[k*AW +: AW]) == a) v = wdata[k*DW +: DW];
            end
        end
        return v;
    endfunction

    function automatic bit exp_rbusy(int i, bit byp);
        int a = int'(raddr[i*AW +: AW]);
        bit b;
        if (rst) return 1'b0;
        b = mdl_busy[a];
        if (byp) begin
            for (int k = 0; k < NR_WR; k++) begin
                if (wen[k] && int'(waddr[k*AW +: AW]) == a) b = 1'b0;
            end
        end
        return b;
    endfunction

    function automatic logic [DEPTH-1:0] exp_busy();
        logic [DEPTH-1:0] v;
        for (int r = 0; r < DEPTH; r++) v[r] = mdl_busy[r];
        return v;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < DEPTH; r++) begin
            mdl_rf[r]   = '0;
            mdl_busy[r] = 1'b0;
        end
    endtask

    // Apply the current inputs to the model as the coming clock edge would.
    task automatic model_step();
        bit nb [DEPTH];
        for (int r = 0; r < DEPTH; r++) nb[r] = mdl_busy[r];
        for (int k = 0; k < NR_WR; k++) begin
            int a = int'(waddr[k*AW +: AW]);
            if (wen[k] && a != 0) begin
                mdl_rf[a] = wdata[k*DW +: DW];
                nb[a]     = 1'b0;
            end
        end
        if (iss_en && iss_addr != 0) nb[iss_addr] = 1'b1;
        for (int r = 0; r < DEPTH; r++) mdl_busy[r] = nb[r];
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wen    = '0;
        waddr  = '0;
        wdata  = '0;
        iss_en = 1'b0;
        iss_addr = '0;
    endtask

    task automatic test_reset();
        // Reset state while rst is held
        n_checks++;
        if (busy_b !== '0 || rdata_b !== '0 || rbusy_b !== '0)
            $display("FAIL reset_hold busy=%h rdata=%h rbusy=%b required all zero", busy_b, rdata_b, rbusy_b);
        else n_pass++;
        rst = 1'b0;
        #1;
        // Load x5 and make x6 busy
        wen = 2'b01; waddr = {5'd0, 5'd5}; wdata = {32'd0, 32'hDEADBEEF};
        iss_en = 1'b1; iss_addr = 5'd6;
        tick();
        idle();
        raddr = {5'd6, 5'd5};
        #1;
        n_checks++;
        if (rdata_b[31:0] !== 32'hDEADBEEF || busy_b[6] !== 1'b1)
            $display("FAIL reset_preload rdata=%h busy6=%b required deadbeef/1", rdata_b[31:0], busy_b[6]);
        else n_pass++;
        // Mid-cycle reset while another write is presented
        wen = 2'b01; waddr = {5'd0, 5'd5}; wdata = {32'd0, 32'h12345678};
        #2 rst = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if (rdata_b !== '0 || rdata_n !== '0 || rbusy_b !== '0 || busy_b !== '0)
            $display("FAIL reset_async rdata=%h rbusy=%b busy=%h required zero", rdata_b, rbusy_b, busy_b);
        else n_pass++;
        idle();
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        n_checks++;
        if (rdata_b[31:0] !== 32'd0 || busy_b !== '0 || busy_n !== '0)
            $display("FAIL reset_release rdata=%h busy=%h required 0/0", rdata_b[31:0], busy_b);
        else n_pass++;
    endtask

    task automatic test_zero_reg();
        wen = 2'b01; waddr = {5'd0, 5'd0}; wdata = {32'd0, 32'h1234};
        iss_en = 1'b1; iss_addr = 5'd0;
        raddr = {5'd0, 5'd0};
        #1;
        n_checks++;
        if (rdata_b !== '0 || rbusy_b !== '0)
            $display("FAIL x0_same_cycle rdata=%h rbusy=%b required 0", rdata_b, rbusy_b);
        else n_pass++;
        tick();
        idle();
        #1;
        n_checks++;
        if (rdata_b !== '0 || rdata_n !== '0 || busy_b[0] !== 1'b0 || busy_n[0] !== 1'b0)
            $display("FAIL x0_after rdata=%h busy0=%b required 0/0", rdata_b, busy_b[0]);
        else n_pass++;
    endtask

    task automatic test_bypass();
        wen = 2'b01; waddr = {5'd0, 5'd7}; wdata = {32'd0, 32'h11};
        tick();
        wdata = {32'd0, 32'h22};
        raddr = {5'd0, 5'd7};
        #1;
        n_checks++;
        if (rdata_b[31:0] !== 32'h22)
            $display("FAIL bypass_on got=%h required=%h", rdata_b[31:0], 32'h22);
        else n_pass++;
        n_checks++;
        if (rdata_n[31:0] !== 32'h11)
            $display("FAIL bypass_off got=%h required=%h", rdata_n[31:0], 32'h11);
        else n_pass++;
        tick();
        idle();
        #1;
        n_checks++;
        if (rdata_b[31:0] !== 32'h22 || rdata_n[31:0] !== 32'h22)
            $display("FAIL bypass_after got=%h/%h required 22", rdata_b[31:0], rdata_n[31:0]);
        else n_pass++;
    endtask

    task automatic test_multi_write();
        wen = 2'b11; waddr = {5'd3, 5'd3}; wdata = {32'hBB, 32'hAA};
        raddr = {5'd3, 5'd0};
        #1;
        n_checks++;
        if (rdata_b[63:32] !== 32'hBB)
            $display("FAIL multiwr_bypass got=%h required=%h", rdata_b[63:32], 32'hBB);
        else n_pass++;
        tick();
        idle();
        #1;
        n_checks++;
        if (rdata_b[63:32] !== 32'hBB || rdata_n[63:32] !== 32'hBB)
            $display("FAIL multiwr_after got=%h/%h required bb", rdata_b[63:32], rdata_n[63:32]);
        else n_pass++;
    endtask

    task automatic test_scoreboard();
        iss_en = 1'b1; iss_addr = 5'd9;
        tick();
        idle();
        raddr = {5'd9, 5'd9};
        #1;
        n_checks++;
        if (busy_b[9] !== 1'b1 || rbusy_b !== 2'b11 || rbusy_n !== 2'b11)
            $display("FAIL sb_issue busy9=%b rbusy=%b/%b required 1/11/11", busy_b[9], rbusy_b, rbusy_n);
        else n_pass++;
        wen = 2'b10; waddr = {5'd9, 5'd0}; wdata = {32'h99, 32'd0};
        #1;
        n_checks++;
        if (rbusy_b !== 2'b00 || rbusy_n !== 2'b11)
            $display("FAIL sb_wb_cycle rbusy=%b/%b required 00/11", rbusy_b, rbusy_n);
        else n_pass++;
        tick();
        idle();
        #1;
        n_checks++;
        if (busy_b[9] !== 1'b0 || busy_n[9] !== 1'b0 || rbusy_n !== 2'b00)
            $display("FAIL sb_wb_after busy9=%b/%b required 0", busy_b[9], busy_n[9]);
        else n_pass++;
    endtask

    task automatic test_collision();
        iss_en = 1'b1; iss_addr = 5'd4;
        wen = 2'b01; waddr = {5'd0, 5'd4}; wdata = {32'd0, 32'h4444};
        tick();
        idle();
        raddr = {5'd0, 5'd4};
        #1;
        n_checks++;
        if (busy_b[4] !== 1'b1 || busy_n[4] !== 1'b1)
            $display("FAIL collide_busy got=%b/%b required 1", busy_b[4], busy_n[4]);
        else n_pass++;
        n_checks++;
        if (rdata_b[31:0] !== 32'h4444)
            $display("FAIL collide_data got=%h required=%h", rdata_b[31:0], 32'h4444);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            wen = 2'($urandom);
            for (int k = 0; k < NR_WR; k++) begin
                waddr[k*AW +: AW] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
                wdata[k*DW +: DW] = $urandom;
            end
            for (int i = 0; i < NR_RD; i++)
                raddr[i*AW +: AW] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            iss_en   = ($urandom_range(0, 2) == 0);
            iss_addr = 5'($urandom_range(0, 7));
            #1;
            for (int i = 0; i < NR_RD; i++) begin
                n_checks++;
                if (rdata_b[i*DW +: DW] !== exp_rdata(i, 1'b1) || rdata_n[i*DW +: DW] !== exp_rdata(i, 1'b0))
                    $display("FAIL rand_rdata cyc=%0d port=%0d got=%h/%h required=%h/%h", c, i,
                             rdata_b[i*DW +: DW], rdata_n[i*DW +: DW], exp_rdata(i, 1'b1), exp_rdata(i, 1'b0));
                else n_pass++;
                n_checks++;
                if (rbusy_b[i] !== exp_rbusy(i, 1'b1) || rbusy_n[i] !== exp_rbusy(i, 1'b0))
                    $display("FAIL rand_rbusy cyc=%0d port=%0d got=%b/%b required=%b/%b", c, i,
                             rbusy_b[i], rbusy_n[i], exp_rbusy(i, 1'b1), exp_rbusy(i, 1'b0));
                else n_pass++;
            end
            tick();
            n_checks++;
            if (busy_b !== exp_busy() || busy_n !== exp_busy())
                $display("FAIL rand_busy cyc=%0d got=%h/%h required=%h", c, busy_b, busy_n, exp_busy());
            else n_pass++;
        end
        idle();
    endtask

    initial begin
        rst   = 1'b1;
        raddr = '0;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_zero_reg();
        test_bypass();
        test_multi_write();
        test_scoreboard();
        test_collision();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
